// File: rtl/program_counter_fetch.sv
// Program counter and instruction-fetch sequencer: issues req/ack fetches to
// instruction memory, delivers instructions to decode and squashes wrong-path fetches on jumps.
module program_counter_fetch #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_offset,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_ack,
  input  logic [ADDR_WIDTH-1:0] fetch_data,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [ADDR_WIDTH-1:0] last_pc, last_pc_nxt;
  logic [ADDR_WIDTH-1:0] pending_target, pending_target_nxt;
  logic                  pending_jump, pending_jump_nxt;
  logic                  instr_valid_nxt;
  logic [ADDR_WIDTH-1:0] instr_nxt;
  logic [ADDR_WIDTH-1:0] target;

  // Jumps are relative to the last delivered instruction, not the fetch address.
  assign target     = last_pc + jump_offset;
  assign fetch_addr = pc;
  assign pc_out     = last_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_VECTOR;
      last_pc        <= RESET_VECTOR;
      pending_jump   <= 1'b0;
      pending_target <= '0;
      instr_valid    <= 1'b0;
      instr_out      <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      last_pc        <= last_pc_nxt;
      pending_jump   <= pending_jump_nxt;
      pending_target <= pending_target_nxt;
      instr_valid    <= instr_valid_nxt;
      instr_out      <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    pc_nxt             = pc;
    last_pc_nxt        = last_pc;
    pending_jump_nxt   = pending_jump;
    pending_target_nxt = pending_target;
    instr_valid_nxt    = 1'b0;
    instr_nxt          = instr_out;
    fetch_req          = 1'b0;
    unique case (state)
      IDLE: state_nxt = stall ? HOLD : FETCH;
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          state_nxt        = stall ? HOLD : FETCH;
          pending_jump_nxt = 1'b0;
          // A jump arriving with the ack beats any jump remembered earlier.
          if (jump_valid) begin
            pc_nxt = target;
          end else if (pending_jump) begin
            pc_nxt = pending_target;
          end else begin
            instr_valid_nxt = 1'b1;
            instr_nxt       = fetch_data;
            last_pc_nxt     = pc;
            pc_nxt          = pc + ADDR_WIDTH'(1);
          end
        end else if (jump_valid) begin
          pending_jump_nxt   = 1'b1;
          pending_target_nxt = target;
        end
      end
      HOLD: begin
        if (jump_valid) pc_nxt = target;
        if (!stall) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/program_counter_fetch.md
Name: program_counter_fetch

Overview:
- Program-counter and instruction-fetch sequencer that sits directly downstream of the jump/compare stages.
- Holds the 16-bit PC and issues fetch requests to instruction memory over a req/ack handshake.
- Delivers fetched instructions to decode.
- Consumes jump pulses plus relative offsets from the jump stages, squashes wrong-path fetches and redirects the PC.

Parameters:
ADDR_WIDTH, 16, width of PC, fetch address, offset and instruction word
RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
stall  input  1  decode back-pressure; 1 = do not start new fetches
jump_valid  input  1  one-cycle pulse from a jump stage: take branch
jump_offset  input  ADDR_WIDTH  two's-complement relative offset, valid with jump_valid
fetch_req  output  1  fetch request to instruction memory
fetch_addr  output  ADDR_WIDTH  fetch address, stable while fetch_req=1
fetch_ack  input  1  memory has fetch_data valid this cycle
fetch_data  input  ADDR_WIDTH  instruction word from memory
instr_valid  output  1  one-cycle pulse: instr_out holds a correct-path instruction
instr_out  output  ADDR_WIDTH  delivered instruction word
pc_out  output  ADDR_WIDTH  address of the most recently delivered instruction (last_pc)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - pc = RESET_VECTOR; last_pc = RESET_VECTOR; pc_out = RESET_VECTOR.
  - fetch_req = 0; instr_valid = 0; instr_out = 0.
  - pending_jump = 0; pending_target = 0.
  - state = IDLE.
- Internal registers: pc (next fetch address), last_pc, pending_jump, pending_target.
- Jump target: target = last_pc + jump_offset, modulo 2^ADDR_WIDTH (wraps, no saturation).
- States:
  - IDLE: entered only from reset; fetch_req=0; jump_valid ignored. Next cycle: stall ? HOLD : FETCH.
  - FETCH:
    - Outputs: fetch_req=1, fetch_addr=pc. pc and fetch_addr must not change until fetch_ack.
    - Without fetch_ack: if jump_valid, pending_jump<=1 and pending_target<=target; a later jump overwrites the earlier one (latest wins). stall is ignored while the request is outstanding.
    - On fetch_ack with pending_jump=1 or jump_valid=1 (jump_valid has priority for target): discard fetch_data; instr_valid stays 0; pc<=target; pending_jump<=0.
    - On fetch_ack with no jump: instr_out<=fetch_data; instr_valid<=1 next cycle; last_pc<=pc; pc<=pc+1 (wraps 16'hFFFF -> 16'h0000).
    - After ack: stall ? HOLD : FETCH. Staying in FETCH re-raises the request with the new address the next cycle. Back-to-back acks give one instruction per cycle.
  - HOLD:
    - fetch_req=0.
    - jump_valid: pc<=target immediately; no pending state.
    - Leave for FETCH the cycle after stall is sampled 0.
- instr_valid is high for exactly one cycle per accepted fetch; it is never asserted for a squashed fetch.
- pc_out updates together with instr_valid.
- fetch_ack outside FETCH is ignored.
- Reset mid-request: all state returns to reset values immediately (asynchronous). The outstanding request is dropped and the memory must tolerate it.
- Latency: request issued the cycle after FETCH entry; instruction visible the cycle after fetch_ack.

Test Plan:
- Reset release, stall=0, memory acks the same cycle as the request, data = addr ^ 16'hA5A5 -> fetch_addr 0,1,2,3 on consecutive cycles; instr_valid continuous from the first ack+1; pc_out 0,1,2,3.
- Memory ack delay 3 cycles; jump_valid with offset 16'h0010 while fetch at addr 5 is outstanding (last_pc=4) -> fetch_addr held at 5 until ack; data from 5 dropped (no instr_valid); next fetch_addr = 16'h0014.
- Two jump_valid pulses during one outstanding fetch, offsets +8 then -2, last_pc=16'h0020 -> second wins; next fetch_addr = 16'h001E.
- Assert stall during an outstanding fetch at addr 7 -> request completes, instruction 7 delivered, fetch_req=0 while stalled; jump +3 while held with last_pc=7 -> next fetch_addr = 16'h000A after stall drops.
- RESET_VECTOR=16'hFFFE, sequential fetches -> fetch_addr FFFE, FFFF, 0000; negative offset 16'hFFFC from last_pc 16'h0001 -> target 16'hFFFD.
- Assert rst_n low mid-request at addr 9 -> fetch_req, instr_valid 0 immediately; after release first fetch_addr = RESET_VECTOR; no stale pending jump taken.
